gate_sweep_controller: RTL and testbench

- Sequencer that drives the two-input basic gate unit. The gate unit has inputs A, B and outputs Y1..Y7, where Y1=AND, Y2=OR, Y3=NOT A, Y4=NAND, Y5=NOR, Y6=XOR, Y7=XNOR.
- On request, the block steps A,B through all four input vectors and samples all seven outputs per vector. It packs the sampled outputs into a 28-bit truth table and compares it against a golden table.
- Sits beside the gate unit as an in-hardware replacement for manual stimulus: A/B outputs connect to the gate unit inputs; Y1..Y7 return from the gate unit outputs.

---
 rtl/gate_sweep_if.sv | 30 +++
 rtl/gate_sweep_controller.sv | 145 ++++++++++++++
 tb/tb_gate_sweep_controller.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/gate_sweep_if.sv
// Handshake and result bundle between the sweep controller and its environment.
// The slave modport is the controller. The master modport is the requester/gate-unit side.
interface gate_sweep_if;
    logic        start;
    logic        abort;
    logic        y1;
    logic        y2;
    logic        y3;
    logic        y4;
    logic        y5;
    logic        y6;
    logic        y7;
    logic        a;
    logic        b;
    logic        busy;
    logic        done;
    logic        pass;
    logic [6:0]  fail_mask;
    logic [27:0] truth;

    modport slave (
        input  start, abort, y1, y2, y3, y4, y5, y6, y7,
        output a, b, busy, done, pass, fail_mask, truth
    );

    modport master (
        output start, abort, y1, y2, y3, y4, y5, y6, y7,
        input  a, b, busy, done, pass, fail_mask, truth
    );
endinterface

// File: rtl/gate_sweep_controller.sv
// Steps the two-input gate unit through vectors 00, 01, 10, 11 (A is the MSB).
// It holds each vector for HOLD_CYCLES cycles and samples Y1..Y7 in the last cycle of each hold.
// The sampled outputs form a 28-bit truth table, which is compared against GOLDEN.
// Truth table bit (k-1)*4 + v holds output Yk for vector v = {A,B}.
module gate_sweep_controller #(
    parameter int          HOLD_CYCLES = 4,          // legal range 1..255
    parameter logic [27:0] GOLDEN      = 28'h96173E8
) (
    input  logic         clk,
    input  logic         rst_n,
    gate_sweep_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  hold_cnt;
    logic [1:0]  vec_idx;      // current vector; drives A,B directly
    logic [27:0] truth_q;
    logic        pass_q;
    logic        done_q;
    logic [6:0]  fail_mask_q;

    logic        hold_last;
    logic        start_sweep;
    logic        sample_en;
    logic        check_en;
    logic        abort_en;
    logic [6:0]  y_vec;
    logic [27:0] diff;
    logic [6:0]  mismatch;

    assign y_vec     = {bus.y7, bus.y6, bus.y5, bus.y4, bus.y3, bus.y2, bus.y1};
    assign hold_last = (hold_cnt == HOLD_LAST);

    // State register.
    // NOTE: every clocked block uses non-blocking (<=) so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; ABORT beats both START and normal progress.
    // NOTE: state_nxt is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start && !bus.abort) state_nxt = S_RUN;
            S_RUN: begin
                if (bus.abort)                           state_nxt = S_IDLE;
                else if (hold_last && vec_idx == 2'd3)   state_nxt = S_CHECK;
            end
            S_CHECK: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control strobes decoded from the current state and requests.
    always_comb begin
        start_sweep = 1'b0;
        sample_en   = 1'b0;
        check_en    = 1'b0;
        abort_en    = 1'b0;
        case (state)
            S_IDLE:  start_sweep = bus.start & ~bus.abort;
            S_RUN: begin
                abort_en  = bus.abort;
                sample_en = ~bus.abort & hold_last;
            end
            S_CHECK: begin
                abort_en = bus.abort;
                check_en = ~bus.abort;
            end
            default: ;
        endcase
    end

    // Per-gate mismatch: OR-reduce each nibble of the captured/golden difference.
    always_comb begin
        diff     = truth_q ^ GOLDEN;
        mismatch = '0;
        for (int k = 0; k < 7; k++) mismatch[k] = |diff[4*k +: 4];
    end

    // Hold counter and vector index. The index wraps 3 -> 0 when the last vector is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            vec_idx  <= '0;
        end else if (start_sweep || abort_en || state != S_RUN) begin
            hold_cnt <= '0;
            vec_idx  <= '0;
        end else if (hold_last) begin
            hold_cnt <= '0;
            vec_idx  <= vec_idx + 2'd1;
        end else begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    // Result registers: truth capture, verdict, and the one-cycle DONE pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            truth_q     <= '0;
            pass_q      <= 1'b0;
            fail_mask_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= check_en;
            if (start_sweep) begin
                truth_q     <= '0;
                pass_q      <= 1'b0;
                fail_mask_q <= '0;
            end else if (abort_en) begin
                // Partial truth table is left in place for inspection.
                pass_q      <= 1'b0;
                fail_mask_q <= '0;
            end else if (check_en) begin
                pass_q      <= (truth_q == GOLDEN);
                fail_mask_q <= mismatch;
            end
            if (sample_en) begin
                for (int k = 0; k < 7; k++)
                    for (int v = 0; v < 4; v++)
                        if (vec_idx == 2'(v)) truth_q[4*k + v] <= y_vec[k];
            end
        end
    end

    assign bus.a         = vec_idx[1];
    assign bus.b         = vec_idx[0];
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.truth     = truth_q;

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Directed bench for gate_sweep_controller.
// One instance uses HOLD_CYCLES=4 with an optionally faulty gate model. A second instance uses HOLD_CYCLES=1.
module tb_gate_sweep_controller;

    localparam logic [27:0] GOLD    = 28'h96173E8;
    localparam logic [27:0] GOLD_Y6 = 28'h90173E8;  // Y6 stuck at 0
    localparam logic [27:0] PARTIAL = 28'h1213320;  // vectors 00 and 01 only

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fault = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    gate_sweep_if bus4();
    gate_sweep_if bus1();

    gate_sweep_controller #(.HOLD_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    gate_sweep_controller #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Gate unit models
    assign bus4.y1 = bus4.a & bus4.b;
    assign bus4.y2 = bus4.a | bus4.b;
    assign bus4.y3 = ~bus4.a;
    assign bus4.y4 = ~(bus4.a & bus4.b);
    assign bus4.y5 = ~(bus4.a | bus4.b);
    assign bus4.y6 = fault ? 1'b0 : (bus4.a ^ bus4.b);
    assign bus4.y7 = ~(bus4.a ^ bus4.b);

    assign bus1.y1 = bus1.a & bus1.b;
    assign bus1.y2 = bus1.a | bus1.b;
    assign bus1.y3 = ~bus1.a;
    assign bus1.y4 = ~(bus1.a & bus1.b);
    assign bus1.y5 = ~(bus1.a | bus1.b);
    assign bus1.y6 = bus1.a ^ bus1.b;
    assign bus1.y7 = ~(bus1.a ^ bus1.b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full sweep on the HOLD_CYCLES=4 instance, with optional START re-pulses at cycles 3 and 10.
    task automatic sweep4(input string tag, input bit repulse, input logic [27:0] exp_truth,
                          input logic exp_pass, input logic [6:0] exp_mask);
        logic [1:0] v;
        bus4.start = 1'b1;
        tick();                                   // edge 0
        bus4.start = 1'b0;
        check({tag, "_e0"}, {28'd0, bus4.a, bus4.b, bus4.busy, bus4.done}, 32'b0010);
        check({tag, "_pass_clr"}, {31'd0, bus4.pass}, 32'd0);
        check({tag, "_mask_clr"}, {25'd0, bus4.fail_mask}, 32'd0);
        for (int e = 1; e <= 17; e++) begin
            bus4.start = repulse && (e == 4 || e == 11);
            tick();
            bus4.start = 1'b0;
            v = (e < 16) ? 2'(e / 4) : 2'b00;
            check($sformatf("%s_e%0d", tag, e),
                  {28'd0, bus4.a, bus4.b, bus4.busy, bus4.done},
                  {28'd0, v, (e <= 16) ? 1'b1 : 1'b0, (e == 17) ? 1'b1 : 1'b0});
        end
        check({tag, "_truth"}, {4'd0, bus4.truth}, {4'd0, exp_truth});
        check({tag, "_pass"}, {31'd0, bus4.pass}, {31'd0, exp_pass});
        check({tag, "_mask"}, {25'd0, bus4.fail_mask}, {25'd0, exp_mask});
        tick();
        check({tag, "_done_once"}, {30'd0, bus4.busy, bus4.done}, 32'd0);
    endtask

    initial begin
        bit seen_done;
        bus4.start = 1'b0; bus4.abort = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0;

        // Reset state
        #12;
        check("rst_ctl4", {28'd0, bus4.a, bus4.b, bus4.busy, bus4.done}, 32'd0);
        check("rst_res4", {bus4.pass, bus4.fail_mask, bus4.truth}, 32'd0);
        check("rst_ctl1", {28'd0, bus1.a, bus1.b, bus1.busy, bus1.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Correct gate model
        sweep4("good", 1'b0, GOLD, 1'b1, 7'h00);

        // ABORT in IDLE keeps last results
        bus4.abort = 1'b1;
        tick();
        bus4.abort = 1'b0;
        check("idle_abort_busy", {31'd0, bus4.busy}, 32'd0);
        check("idle_abort_pass", {31'd0, bus4.pass}, 32'd1);
        check("idle_abort_truth", {4'd0, bus4.truth}, {4'd0, GOLD});

        // Y6 stuck at 0
        fault = 1'b1;
        sweep4("y6_stuck", 1'b0, GOLD_Y6, 1'b0, 7'b0100000);
        fault = 1'b0;

        // START re-pulsed while busy
        sweep4("repulse", 1'b1, GOLD, 1'b1, 7'h00);

        // ABORT mid-sweep
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        for (int e = 1; e <= 9; e++) tick();
        check("abort_pre", {29'd0, bus4.a, bus4.b, bus4.busy}, 32'b101);
        bus4.abort = 1'b1;
        tick();
        bus4.abort = 1'b0;
        check("abort_idle", {28'd0, bus4.a, bus4.b, bus4.busy, bus4.done}, 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus4.done) seen_done = 1'b1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);
        check("abort_truth", {4'd0, bus4.truth}, {4'd0, PARTIAL});
        check("abort_pass", {31'd0, bus4.pass}, 32'd0);
        check("abort_mask", {25'd0, bus4.fail_mask}, 32'd0);

        // START and ABORT together in IDLE
        bus4.start = 1'b1;
        bus4.abort = 1'b1;
        tick();
        bus4.start = 1'b0;
        bus4.abort = 1'b0;
        check("start_abort_idle", {31'd0, bus4.busy}, 32'd0);

        // Asynchronous reset between edges mid-sweep
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        check("prerst_busy", {29'd0, bus4.a, bus4.b, bus4.busy}, 32'b011);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ctl", {28'd0, bus4.a, bus4.b, bus4.busy, bus4.done}, 32'd0);
        check("midrst_res", {bus4.pass, bus4.fail_mask, bus4.truth}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        sweep4("post_rst", 1'b0, GOLD, 1'b1, 7'h00);

        // HOLD_CYCLES=1, START held high: back-to-back sweeps
        bus1.start = 1'b1;
        tick();                                   // edge 0
        for (int e = 1; e <= 11; e++) begin
            tick();
            check($sformatf("h1_done_e%0d", e), {31'd0, bus1.done},
                  (e == 5 || e == 11) ? 32'd1 : 32'd0);
            if (e <= 3)
                check($sformatf("h1_ab_e%0d", e), {30'd0, bus1.a, bus1.b}, 32'(e));
            if (e == 5 || e == 11)
                check($sformatf("h1_pass_e%0d", e), {31'd0, bus1.pass}, 32'd1);
            if (e == 6)
                check("h1_restart_clr", {30'd0, bus1.busy, bus1.pass}, 32'b10);
        end
        bus1.start = 1'b0;
        check("h1_truth", {4'd0, bus1.truth}, {4'd0, GOLD});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
